klp32_dmem: RTL and testbench

Data-memory responder for the KLP32V1 core: the target side of the core's load/store interface (address from the ALU, write-enable `memRW`, read data returned as `dataMemReadOut`). It accepts one request at a time through a req/ready handshake and inserts a configurable number of wait states. It performs RV32I byte, halfword and word loads and stores with sign/zero extension and byte-lane masking. Misaligned, out-of-range and illegal-size accesses are reported through an error flag.

---
 rtl/klp32_pkg.sv | 18 +
 rtl/klp32_mem_align.sv | 69 ++++++
 rtl/klp32_dmem.sv | 145 ++++++++++++++
 tb/tb_klp32_dmem.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/klp32_pkg.sv
// Shared KLP32V1 definitions: RV32I load/store funct3 encodings and data-memory FSM states.
package klp32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/klp32_mem_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store data,
// sign/zero-extended load data, and misalignment / illegal-funct3 detection.
module klp32_mem_align
  import klp32_pkg::*;
(
  input  logic [1:0]      addrLo,
  input  logic [2:0]      funct3,
  input  logic            isStore,
  input  logic [XLEN-1:0] storeData,
  input  logic [XLEN-1:0] rawWord,
  output logic [3:0]      byteEn,
  output logic [XLEN-1:0] laneData,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned,
  output logic            badFunct3
);

  logic [XLEN-1:0] shifted;

  assign shifted = rawWord >> {addrLo, 3'b000};

  always_comb begin
    byteEn   = 4'b0000;
    laneData = '0;
    unique case (funct3[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << addrLo;
        laneData = {4{storeData[7:0]}};
      end
      2'b01: begin
        byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
        laneData = {2{storeData[15:0]}};
      end
      2'b10: begin
        byteEn   = 4'b1111;
        laneData = storeData;
      end
      default: begin
        byteEn   = 4'b0000;
        laneData = '0;
      end
    endcase
  end

  always_comb begin
    loadData = '0;
    unique case (funct3)
      F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    loadData = shifted;
      F3_BU:   loadData = {24'd0, shifted[7:0]};
      F3_HU:   loadData = {16'd0, shifted[15:0]};
      default: loadData = '0;
    endcase
  end

  assign misaligned = ((funct3[1:0] == 2'b01) && addrLo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addrLo != 2'b00));

  always_comb begin
    if (isStore) begin
      badFunct3 = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end else begin
      badFunct3 = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU));
    end
  end

endmodule

// File: rtl/klp32_dmem.sv
// KLP32V1 data-memory responder: one request at a time, configurable wait states,
// byte/half/word access with error reporting.
module klp32_dmem
  import klp32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_t stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic        weQ;
  logic [31:0] addrQ, wdataQ;
  logic [2:0]  f3Q;
  logic [31:0] rdataQ;
  logic        errQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic            accept, enterResp, doWrite;
  logic            curWe;
  logic [31:0]     curAddr, curWdata;
  logic [2:0]      curF3;
  logic [AW-1:0]   wordIdx;
  logic [31:0]     rawWord, laneData, loadData;
  logic [3:0]      byteEn;
  logic            misaligned, badFunct3, rangeErr, curErr;

  assign accept = (stateQ == IDLE) && i_req;

  // With zero wait states the access completes on the acceptance edge, so the
  // live inputs are used directly instead of the not-yet-latched copy.
  assign curWe    = (stateQ == IDLE) ? i_we     : weQ;
  assign curAddr  = (stateQ == IDLE) ? i_addr   : addrQ;
  assign curWdata = (stateQ == IDLE) ? i_wdata  : wdataQ;
  assign curF3    = (stateQ == IDLE) ? i_funct3 : f3Q;

  assign wordIdx  = curAddr[AW+1:2];
  assign rawWord  = mem[wordIdx];
  assign rangeErr = curAddr[31:2] >= 30'(DEPTH_WORDS);
  assign curErr   = badFunct3 | misaligned | rangeErr;

  klp32_mem_align uAlign (
    .addrLo     (curAddr[1:0]),
    .funct3     (curF3),
    .isStore    (curWe),
    .storeData  (curWdata),
    .rawWord    (rawWord),
    .byteEn     (byteEn),
    .laneData   (laneData),
    .loadData   (loadData),
    .misaligned (misaligned),
    .badFunct3  (badFunct3)
  );

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    enterResp = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (i_req) begin
          cntD = WaitInit;
          if (WAIT_STATES == 0) begin
            stateD    = RESP;
            enterResp = 1'b1;
          end else begin
            stateD = WAIT;
          end
        end
      end
      WAIT: begin
        if (cntQ == 4'd0) begin
          stateD    = RESP;
          enterResp = 1'b1;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      f3Q    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        weQ    <= i_we;
        addrQ  <= i_addr;
        wdataQ <= i_wdata;
        f3Q    <= i_funct3;
      end
      if (enterResp) begin
        rdataQ <= (curErr || curWe) ? 32'd0 : loadData;
        errQ   <= curErr;
      end else if (stateQ == RESP) begin
        rdataQ <= '0;
        errQ   <= 1'b0;
      end
    end
  end

  // Gating with reset keeps an IDLE zero-wait store from landing while reset is held.
  assign doWrite = enterResp && curWe && !curErr && !reset;

  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  assign o_ready = (stateQ == RESP);
  assign o_rdata = rdataQ;
  assign o_err   = errQ;
  assign o_busy  = (stateQ != IDLE);

endmodule

// File: tb/tb_klp32_dmem.sv
// Scoreboard bench for klp32_dmem: three instances (0, 1 and 3 wait states) driven in turn.
module tb_klp32_dmem;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        ready [3];
  logic        err   [3];
  logic        busy  [3];
  logic [31:0] rdata [3];
  logic        sWe;
  logic [31:0] sAddr, sWd;
  logic [2:0]  sF3;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit burst0 = 0;
  int lastRdy0 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  klp32_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) uDut0 (
    .clk(clk), .reset(rst[0]), .i_req(req[0]), .i_we(sWe), .i_addr(sAddr), .i_wdata(sWd),
    .i_funct3(sF3), .o_ready(ready[0]), .o_rdata(rdata[0]), .o_err(err[0]), .o_busy(busy[0])
  );
  klp32_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) uDut1 (
    .clk(clk), .reset(rst[1]), .i_req(req[1]), .i_we(sWe), .i_addr(sAddr), .i_wdata(sWd),
    .i_funct3(sF3), .o_ready(ready[1]), .o_rdata(rdata[1]), .o_err(err[1]), .o_busy(busy[1])
  );
  klp32_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) uDut3 (
    .clk(clk), .reset(rst[2]), .i_req(req[2]), .i_we(sWe), .i_addr(sAddr), .i_wdata(sWd),
    .i_funct3(sF3), .o_ready(ready[2]), .o_rdata(rdata[2]), .o_err(err[2]), .o_busy(busy[2])
  );

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", name, d, act, exp);
    end
  endtask

  task automatic note(input string name, input int d);
    total++;
    bad++;
    $display("FAIL %s dut%0d: got event-missing want event", name, d);
  endtask

  task automatic checkResp(input int d);
    exp_t e;
    bit   have = 0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    if (!have) begin
      note("unexpected_ready", d);
    end else begin
      chk("rdata", d, rdata[d], e.rdata);
      chk("err", d, {31'd0, err[d]}, {31'd0, e.err});
      chk("latency", d, cyc - e.acc, wsOf(d));
      chk("busy_in_resp", d, {31'd0, busy[d]}, 32'd1);
      if (d == 0 && burst0) begin
        if (lastRdy0 >= 0) chk("b2b_gap", d, cyc - lastRdy0, 2);
        lastRdy0 = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ready[d]) checkResp(d);
    end
  end

  // Called at a falling edge; returns at the falling edge of the response cycle.
  task automatic doReq(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] expR, input logic expE,
                       input bit hold);
    exp_t e;
    bit   got = 0;
    sWe = we; sF3 = f3; sAddr = addr; sWd = wd;
    req[d] = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (busy[d]) got = 1;
    end
    if (!got) begin
      note("accept_timeout", d);
      req[d] = 1'b0;
      return;
    end
    e.rdata = expR; e.err = expE; e.acc = cyc;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready[d]) got = 1;
    end
    if (!got) note("ready_timeout", d);
    if (!hold) req[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      req[d] = 1'b0;
    end
    sWe = 1'b0; sAddr = '0; sWd = '0; sF3 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, {31'd0, ready[d]}, 32'd0);
      chk("rst_rdata", d, rdata[d], 32'd0);
      chk("rst_err", d, {31'd0, err[d]}, 32'd0);
      chk("rst_busy", d, {31'd0, busy[d]}, 32'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // One wait state: store, loads of every width, sub-word stores, error cases.
    doReq(1, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    doReq(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    doReq(1, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
    doReq(1, 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 0);
    doReq(1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
    doReq(1, 0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, 0);
    doReq(1, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 0);
    doReq(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0);
    doReq(1, 1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0, 0);
    doReq(1, 0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 0, 0);
    doReq(1, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 0);
    doReq(1, 1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1, 0);
    doReq(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);
    doReq(1, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 0);
    doReq(1, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 0);
    doReq(1, 0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 0, 0);

    // Zero wait states, request held high across back-to-back transactions.
    burst0 = 1;
    doReq(0, 1, 3'b010, 32'h40, 32'h11223344, 32'h0, 0, 1);
    doReq(0, 0, 3'b010, 32'h40, 32'h0, 32'h11223344, 0, 1);
    doReq(0, 0, 3'b100, 32'h41, 32'h0, 32'h00000033, 0, 1);
    doReq(0, 0, 3'b001, 32'h42, 32'h0, 32'h00001122, 0, 0);
    burst0 = 0;
    @(negedge clk);

    // Three wait states: a store aborted by reset must never commit.
    doReq(2, 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    sWe = 1'b1; sF3 = 3'b010; sAddr = 32'h20; sWd = 32'h55;
    req[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("busy_in_wait", 2, {31'd0, busy[2]}, 32'd1);
    rst[2] = 1'b1;
    #1;
    chk("abort_ready", 2, {31'd0, ready[2]}, 32'd0);
    chk("abort_rdata", 2, rdata[2], 32'd0);
    chk("abort_err", 2, {31'd0, err[2]}, 32'd0);
    chk("abort_busy", 2, {31'd0, busy[2]}, 32'd0);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (8) @(negedge clk);
    doReq(2, 0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 0);
    doReq(2, 1, 3'b000, 32'h22, 32'h000000C3, 32'h0, 0, 0);
    doReq(2, 0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFC3, 0, 0);

    repeat (4) @(negedge clk);
    chk("q0_drained", 0, q0.size(), 0);
    chk("q1_drained", 1, q1.size(), 0);
    chk("q2_drained", 2, q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
